// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment codes (active-low, bit0 = a) and control FSM states
package seg_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_FINISH} state_t;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
endpackage

// File: rtl/seg_bin2bcd.sv
// seg_bin2bcd: sequential shift-add-3 binary to BCD, one bit per cycle after start_i
module seg_bin2bcd #(
   parameter int DATA_W = 16,
   parameter int BCD_W  = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] bin_i,
   output logic              done_o,
   output logic [BCD_W-1:0]  bcd_o
);
   localparam int CNT_W = $clog2(DATA_W);
   logic [DATA_W-1:0] r_bin;
   logic [BCD_W-1:0]  r_bcd, w_adj;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_run;
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < BCD_W / 4; i++)
         w_adj[4*i +: 4] = (r_bcd[4*i +: 4] > 4'd4) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (start_i) begin
         r_bin <= bin_i;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b1;
      end else if (r_run) begin
         r_bcd <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
         r_bin <= r_bin << 1;
         r_cnt <= r_cnt + CNT_W'(1);
         r_run <= r_cnt != CNT_W'(DATA_W - 1);
      end
   end
   // done_o marks the cycle whose closing edge performs the final shift
   assign done_o = r_run && (r_cnt == CNT_W'(DATA_W - 1));
   assign bcd_o  = r_bcd;
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed seven-segment driver showing a hex or decimal value,
// with leading-zero blanking and overflow dashes; scanning never pauses for loads.
module seg_scan_mux import seg_pkg::*; #(
   parameter  int DIGITS      = 4,
   parameter  int REFRESH_DIV = 50000,
   localparam int DATA_W      = 4 * DIGITS
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] value_i,
   input  logic              mode_i,
   input  logic              blank_lz_i,
   input  logic              load_i,
   output logic              busy_o,
   output logic [6:0]        seg_o,
   output logic [DIGITS-1:0] ss_o
);
   localparam int BCD_W = 4 * (DIGITS + 2);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   state_t            r_state, w_state_nx;
   logic [DATA_W-1:0] r_val;
   logic              r_mode, r_blank;
   logic [6:0]        r_disp [DIGITS];
   logic [6:0]        w_code [DIGITS];
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic [IDX_W-1:0]  r_idx, w_idx_nx;
   logic [6:0]        r_seg, w_seg_nx;
   logic [DIGITS-1:0] r_ss, w_ss_nx;
   logic              w_load, w_done, w_tc, w_zero, w_ovf;
   logic [3:0]        w_nib;
   logic [BCD_W-1:0]  w_bcd;
   assign w_load = load_i && (r_state == ST_IDLE);
   seg_bin2bcd #(.DATA_W(DATA_W), .BCD_W(BCD_W)) u_bcd (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(w_load && mode_i),
      .bin_i  (value_i),
      .done_o (w_done),
      .bcd_o  (w_bcd)
   );
   always_comb begin
      w_state_nx = r_state;
      if (r_state == ST_IDLE && load_i) w_state_nx = mode_i ? ST_CONV : ST_FINISH;
      else if (r_state == ST_CONV && w_done) w_state_nx = ST_FINISH;
      else if (r_state == ST_FINISH) w_state_nx = ST_IDLE;
   end
   // walk from the top digit so w_zero means "this digit and all above are zero"
   always_comb begin
      w_zero = 1'b1;
      w_nib  = '0;
      w_ovf  = r_mode && (w_bcd[BCD_W-1 -: 8] != '0);
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_nib     = r_mode ? w_bcd[4*i +: 4] : r_val[4*i +: 4];
         w_zero    = w_zero && (w_nib == 4'd0);
         w_code[i] = w_ovf ? SEG_DASH : (r_blank && w_zero && i != 0) ? SEG_BLANK : SEG_HEX[w_nib];
      end
   end
   always_comb begin
      w_tc     = r_cnt == CNT_W'(REFRESH_DIV - 1);
      w_cnt_nx = w_tc ? '0 : r_cnt + CNT_W'(1);
      w_idx_nx = !w_tc ? r_idx : (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      w_ss_nx  = (w_cnt_nx == '0) ? '1 : ~(DIGITS'(1) << w_idx_nx);
      w_seg_nx = (r_state == ST_FINISH) ? w_code[w_idx_nx] : r_disp[w_idx_nx];
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_val   <= '0;
         r_mode  <= 1'b0;
         r_blank <= 1'b0;
         r_disp  <= '{default: SEG_BLANK};
         r_cnt   <= '0;
         r_idx   <= '0;
         r_seg   <= SEG_BLANK;
         r_ss    <= '1;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
         r_seg   <= w_seg_nx;
         r_ss    <= w_ss_nx;
         if (w_load) begin
            r_val   <= value_i;
            r_mode  <= mode_i;
            r_blank <= blank_lz_i;
         end
         if (r_state == ST_FINISH) r_disp <= w_code;
      end
   end
   assign busy_o = r_state != ST_IDLE;
   assign seg_o  = r_seg;
   assign ss_o   = r_ss;
endmodule
